// File: rtl/dec_pkg.sv
// Shared mode codes, FSM state encoding and decode helpers for dec_onehot_seq.
package dec_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_SCAN   = 2'b01;
   localparam logic [1:0] MODE_PULSE  = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   // Widest decode supported by onehot(); callers truncate to their own NUM_OUT.
   localparam int unsigned MAX_OUT = 1024;

   typedef enum logic [1:0] {
      StIdle,
      StDirect,
      StScan,
      StPulse
   } state_e;

   function automatic state_e mode_to_state(input logic [1:0] m);
      case (m)
         MODE_DIRECT: return StDirect;
         MODE_SCAN:   return StScan;
         MODE_PULSE:  return StPulse;
         default:     return StIdle;
      endcase
   endfunction

   function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned n);
      if (idx >= n) return '0;
      return MAX_OUT'(1) << idx;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for one cycle every DIV enabled cycles.
module tick_gen #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == CntW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with DIRECT, SCAN and PULSE modes and a valid/ready select port.
module dec_onehot_seq
   import dec_pkg::*;
#(
   parameter int unsigned SEL_W      = 5,
   parameter int unsigned NUM_OUT    = 32,
   parameter int unsigned DIV        = 100000,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic               sel_valid,
   output logic               sel_ready,
   output logic [NUM_OUT-1:0] out,
   output logic [SEL_W-1:0]   cur_idx,
   output logic               wrap,
   output logic               err
);

   state_e               state_q, state_d, mode_st;
   logic [SEL_W-1:0]     idx_q, idx_d;
   logic                 act_q, act_d;
   logic [NUM_OUT-1:0]   out_q, out_d;
   logic                 wrap_q, wrap_d;
   logic                 err_q, err_d;
   logic                 accept, in_range, last_idx;
   logic                 tick, scan_en, scan_clr;

   assign mode_st  = mode_to_state(mode);
   assign accept   = sel_valid && sel_ready;
   assign in_range = 32'(sel) < NUM_OUT;
   assign last_idx = idx_q == SEL_W'(NUM_OUT - 1);
   assign scan_en  = en && (state_q == StScan);
   assign scan_clr = en && (mode_st != state_q);

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (scan_en),
      .clr  (scan_clr),
      .tick (tick)
   );

   // In PULSE, act_q high means the strobe is on the outputs right now.
   always_comb begin
      sel_ready = 1'b0;
      if (en) begin
         unique case (state_q)
            StIdle, StDirect: sel_ready = 1'b1;
            StPulse:          sel_ready = !act_q;
            StScan:           sel_ready = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      act_d   = act_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (en) begin
         state_d = mode_st;
         unique case (state_q)
            StIdle: act_d = 1'b0;
            StDirect: begin
               if (accept && in_range) begin
                  act_d = 1'b1;
                  idx_d = sel;
               end
            end
            StPulse: begin
               if (act_q) begin
                  act_d = 1'b0;
               end else if (accept && in_range) begin
                  act_d = 1'b1;
                  idx_d = sel;
               end
            end
            StScan: begin
               act_d = 1'b1;
               if (tick) begin
                  idx_d  = last_idx ? '0 : idx_q + SEL_W'(1);
                  wrap_d = last_idx;
               end
            end
         endcase
         if (state_q inside {StDirect, StPulse}) err_d = accept && !in_range;
         // The accept above used the old state; the new state decides what survives entry.
         if (state_d != state_q) begin
            unique case (state_d)
               StIdle: act_d = 1'b0;
               StScan: begin
                  idx_d  = '0;
                  act_d  = 1'b0;
                  wrap_d = 1'b0;
               end
               StDirect, StPulse: act_d = act_d && accept && in_range;
            endcase
         end
      end
      out_d = (en && act_d) ? NUM_OUT'(onehot(32'(idx_d), NUM_OUT)) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         act_q   <= 1'b0;
         out_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         act_q   <= act_d;
         out_q   <= out_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign out     = out_q ^ {NUM_OUT{ACTIVE_LOW}};
   assign cur_idx = idx_q;
   assign wrap    = wrap_q;
   assign err     = err_q;

endmodule
